// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants: IV, round constants, padder state encoding and widths.
package sha256_pkg;

    localparam int WORD_W      = 32;
    localparam int CHUNK_W     = 512;
    localparam int CHUNK_WORDS = CHUNK_W / WORD_W;

    localparam logic [31:0] PAD_MARKER = 32'h8000_0000;

    localparam logic [31:0] H0 = 32'h6a09e667;
    localparam logic [31:0] H1 = 32'hbb67ae85;
    localparam logic [31:0] H2 = 32'h3c6ef372;
    localparam logic [31:0] H3 = 32'ha54ff53a;
    localparam logic [31:0] H4 = 32'h510e527f;
    localparam logic [31:0] H5 = 32'h9b05688c;
    localparam logic [31:0] H6 = 32'h1f83d9ab;
    localparam logic [31:0] H7 = 32'h5be0cd19;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {
        FILL = 2'd0,
        EMIT = 2'd1,
        TAIL = 2'd2
    } pad_state_e;

    // Keep the leading nbytes bytes of a big-endian word.
    function automatic logic [31:0] byte_mask(input logic [2:0] nbytes);
        case (nbytes)
            3'd0:    return 32'h0000_0000;
            3'd1:    return 32'hff00_0000;
            3'd2:    return 32'hffff_0000;
            3'd3:    return 32'hffff_ff00;
            default: return 32'hffff_ffff;
        endcase
    endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// Masks the unused bytes of a message word and drops the 0x80 marker right after the data.
module sha256_pad_word
    import sha256_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [2:0]  bytes_i,
    output logic [31:0] word_o
);

    logic [31:0] marker;

    // A full word has no room for the marker; the caller places it in the next word.
    always_comb begin
        case (bytes_i)
            3'd0:    marker = 32'h8000_0000;
            3'd1:    marker = 32'h0080_0000;
            3'd2:    marker = 32'h0000_8000;
            3'd3:    marker = 32'h0000_0080;
            default: marker = 32'h0000_0000;
        endcase
    end

    assign word_o = (data_i & byte_mask(bytes_i)) | marker;

endmodule

// File: rtl/sha256_msg_padder.sv
// Turns a 32-bit word stream into padded 512-bit SHA-256 chunks with first/last flags.
// Define SHA256_PAD_STATS_EN to add the msg_count completed-message counter.
module sha256_msg_padder
    import sha256_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORD_W-1:0]   in_data,
    input  logic                in_last,
    input  logic [2:0]          in_bytes,
    output logic                chunk_valid,
    input  logic                chunk_ready,
    output logic [CHUNK_W-1:0]  chunk_data,
    output logic                chunk_first,
    output logic                chunk_last
`ifdef SHA256_PAD_STATS_EN
    ,
    output logic [31:0]         msg_count
`endif
);

    pad_state_e                              state_q, state_d;
    logic [CHUNK_WORDS-1:0][WORD_W-1:0]      buf_q, buf_d;
    logic [3:0]                              idx_q, idx_d;
    logic [63:0]                             bitlen_q, bitlen_d;
    logic                                    tail_pend_q, tail_pend_d;
    logic                                    tail_mark_q, tail_mark_d;
    logic                                    first_q, first_d;
    logic                                    last_q, last_d;

    logic        acc, hs;
    logic [2:0]  eff_bytes, word_bytes;
    logic [31:0] pad_w;
    logic [63:0] bitlen_inc;
    logic [4:0]  mark_idx;

    assign acc        = in_valid && in_ready;
    assign hs         = chunk_valid && chunk_ready;
    assign eff_bytes  = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
    assign word_bytes = in_last ? eff_bytes : 3'd4;
    assign bitlen_inc = bitlen_q + (in_last ? {58'd0, eff_bytes, 3'd0} : 64'd32);
    // Word that receives the marker: the current one, or the next one when the last word is full.
    assign mark_idx   = {1'b0, idx_q} + {4'd0, (eff_bytes == 3'd4)};

    sha256_pad_word u_pad_word (
        .data_i  (in_data),
        .bytes_i (word_bytes),
        .word_o  (pad_w)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= FILL;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (acc && (in_last || idx_q == 4'd15)) state_d = EMIT;
            EMIT:    if (hs) state_d = tail_pend_q ? TAIL : FILL;
            TAIL:    state_d = EMIT;
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        in_ready    = (state_q == FILL) && !reset;
        chunk_valid = (state_q == EMIT);
    end

    always_comb begin
        buf_d       = buf_q;
        idx_d       = idx_q;
        bitlen_d    = bitlen_q;
        tail_pend_d = tail_pend_q;
        tail_mark_d = tail_mark_q;
        first_d     = first_q;
        last_d      = last_q;
        case (state_q)
            FILL: begin
                if (acc) begin
                    buf_d[idx_q] = in_last ? pad_w : in_data;
                    bitlen_d     = bitlen_inc;
                    if (!in_last) begin
                        last_d = 1'b0;
                        if (idx_q != 4'd15) idx_d = idx_q + 4'd1;
                    end else begin
                        if (eff_bytes == 3'd4 && !mark_idx[4]) buf_d[mark_idx[3:0]] = PAD_MARKER;
                        // The words past the marker are already zero from the clear on the last handshake.
                        if (mark_idx <= 5'd13) begin
                            buf_d[14] = bitlen_inc[63:32];
                            buf_d[15] = bitlen_inc[31:0];
                            last_d    = 1'b1;
                        end else begin
                            tail_pend_d = 1'b1;
                            tail_mark_d = mark_idx[4];
                            last_d      = 1'b0;
                        end
                    end
                end
            end
            EMIT: begin
                if (hs) begin
                    buf_d   = '0;
                    idx_d   = 4'd0;
                    first_d = last_q;
                    last_d  = 1'b0;
                    if (last_q) bitlen_d = 64'd0;
                end
            end
            TAIL: begin
                buf_d       = '0;
                buf_d[0]    = tail_mark_q ? PAD_MARKER : 32'h0;
                buf_d[14]   = bitlen_q[63:32];
                buf_d[15]   = bitlen_q[31:0];
                last_d      = 1'b1;
                tail_pend_d = 1'b0;
                tail_mark_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q       <= '0;
            idx_q       <= 4'd0;
            bitlen_q    <= 64'd0;
            tail_pend_q <= 1'b0;
            tail_mark_q <= 1'b0;
            first_q     <= 1'b1;
            last_q      <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            idx_q       <= idx_d;
            bitlen_q    <= bitlen_d;
            tail_pend_q <= tail_pend_d;
            tail_mark_q <= tail_mark_d;
            first_q     <= first_d;
            last_q      <= last_d;
        end
    end

    assign chunk_data  = buf_q;
    assign chunk_first = first_q;
    assign chunk_last  = last_q;

`ifdef SHA256_PAD_STATS_EN
    logic [31:0] msg_cnt_q, msg_cnt_d;

    always_comb begin
        msg_cnt_d = msg_cnt_q;
        if (hs && last_q) msg_cnt_d = msg_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) msg_cnt_q <= 32'd0;
        else       msg_cnt_q <= msg_cnt_d;
    end

    assign msg_count = msg_cnt_q;
`endif

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Scoreboard bench: a byte-level SHA-256 padding model predicts every chunk the padder emits.
module tb_sha256_msg_padder;

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, in_last;
    logic [31:0]  in_data;
    logic [2:0]   in_bytes;
    logic         chunk_valid, chunk_ready, chunk_first, chunk_last;
    logic [511:0] chunk_data;
`ifdef SHA256_PAD_STATS_EN
    logic [31:0]  msg_count;
`endif

    sha256_msg_padder dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_bytes    (in_bytes),
        .chunk_valid (chunk_valid),
        .chunk_ready (chunk_ready),
        .chunk_data  (chunk_data),
        .chunk_first (chunk_first),
        .chunk_last  (chunk_last)
`ifdef SHA256_PAD_STATS_EN
        ,
        .msg_count   (msg_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] data;
        logic         first;
        logic         last;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] msg[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         n_hs  = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && chunk_valid && chunk_ready) begin
            n_hs++;
            if (exp_q.size() == 0) begin
                chk("spurious_chunk", {511'd0, chunk_valid}, 512'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("chunk_data", chunk_data, mon_e.data);
                chk("chunk_first", {511'd0, chunk_first}, {511'd0, mon_e.first});
                chk("chunk_last", {511'd0, chunk_last}, {511'd0, mon_e.last});
            end
        end
    end

    // Textbook padding on bytes: data, 0x80, zeros to 56 mod 64, 64-bit bit count.
    task automatic push_model();
        logic [7:0]  p[$];
        logic [63:0] bits;
        exp_t        e;
        int          nch;
        p    = msg;
        bits = 64'(msg.size()) << 3;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
        nch = p.size() / 64;
        for (int c = 0; c < nch; c++) begin
            for (int i = 0; i < 16; i++)
                e.data[32*i +: 32] = {p[64*c+4*i], p[64*c+4*i+1], p[64*c+4*i+2], p[64*c+4*i+3]};
            e.first = (c == 0);
            e.last  = (c == nch - 1);
            exp_q.push_back(e);
        end
    endtask

    // Entered and left just after a rising edge.
    task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
        logic ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_bytes = nb;
        for (int t = 0; t < 1000 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("in_ready_timeout", {511'd0, ok}, 512'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_cur(input bit trail_empty);
        int          L, nw, nb;
        logic [31:0] w;
        L = msg.size();
        push_model();
        nw = (L + 3) / 4;
        if (L == 0) send_word(32'hc3c3_c3c3, 1'b1, 3'd0);
        for (int i = 0; i < nw; i++) begin
            nb = (L - 4*i > 4) ? 4 : L - 4*i;
            for (int b = 0; b < 4; b++)
                w[31-8*b -: 8] = (b < nb) ? msg[4*i+b] : 8'h5a;
            send_word(w, (i == nw - 1) && !trail_empty, 3'(nb));
        end
        if (trail_empty && L != 0) send_word(32'hdead_beef, 1'b1, 3'd0);
        @(negedge clk);
        chk("emit_latency", {511'd0, chunk_valid}, 512'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_msg(input int L, input bit trail_empty, input logic [7:0] seed);
        msg.delete();
        for (int i = 0; i < L; i++) msg.push_back(8'(seed + 8'(i * 7)));
        send_cur(trail_empty);
    endtask

    task automatic set_abc();
        msg.delete();
        msg.push_back(8'h61);
        msg.push_back(8'h62);
        msg.push_back(8'h63);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 3000 && !done; t++) begin
            @(negedge clk);
            done = (exp_q.size() == 0);
        end
        if (!done) chk("drain_timeout", 512'(exp_q.size()), 512'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [511:0] snap;
        int           hs0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        in_data     = 32'h0;
        in_bytes    = 3'd0;
        chunk_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {511'd0, in_ready}, 512'd0);
        chk("rst_chunk_valid", {511'd0, chunk_valid}, 512'd0);
        chk("rst_chunk_data", chunk_data, 512'd0);
        chk("rst_chunk_first", {511'd0, chunk_first}, 512'd1);
        chk("rst_chunk_last", {511'd0, chunk_last}, 512'd0);
`ifdef SHA256_PAD_STATS_EN
        chk("rst_msg_count", {480'd0, msg_count}, 512'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", {511'd0, in_ready}, 512'd1);
        @(posedge clk);
        #1;

        set_abc();
        send_cur(1'b0);
        send_msg(0, 1'b0, 8'h00);
        send_msg(56, 1'b0, 8'h11);
        send_msg(64, 1'b0, 8'h22);
        send_msg(55, 1'b0, 8'h33);
        send_msg(60, 1'b0, 8'h44);
        send_msg(8, 1'b1, 8'h55);
        send_msg(64, 1'b1, 8'h66);
        send_msg(130, 1'b0, 8'h77);
        for (int r = 0; r < 4; r++) send_msg(int'($urandom_range(1, 150)), 1'b0, 8'($urandom));
        drain();

        // Backpressure: chunk must hold and input must stall.
        chunk_ready = 1'b0;
        set_abc();
        send_cur(1'b0);
        snap = chunk_data;
        hs0  = n_hs;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_data", chunk_data, snap);
            chk("stall_in_ready", {511'd0, in_ready}, 512'd0);
            chk("stall_valid", {511'd0, chunk_valid}, 512'd1);
        end
        @(posedge clk);
        #1;
        chunk_ready = 1'b1;
        drain();
        chk("stall_handshakes", 512'(n_hs - hs0), 512'd1);

        // Reset mid-message discards the partial chunk.
        for (int i = 0; i < 7; i++) send_word(32'h0101_0101 * 32'(i + 1), 1'b0, 3'd4);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        set_abc();
        send_cur(1'b0);
        drain();
`ifdef SHA256_PAD_STATS_EN
        @(negedge clk);
        chk("msg_count_after_rst", {480'd0, msg_count}, 512'd1);
`endif
        chk("queue_empty", 512'(exp_q.size()), 512'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sha256_msg_padder.md
# sha256_msg_padder

Front end of the SHA-256 datapath: accepts a message as a stream of 32-bit big-endian words and emits fully padded 512-bit chunks, with the 0x80 marker, zero fill and the 64-bit big-endian bit length, ready for the pipelined chunk compressor. Each chunk carries first/last flags so that downstream logic chooses between the IV (H0..H7) and the chained hash. Word i of a chunk occupies `chunk_data[32*i+:32]`, matching the compressor's `memorychunk` layout.

## Interface
- No parameters. Chunk size is fixed at 512 bits and word width at 32 bits.
- `clk` in 1 — clock.
- `reset` in 1 — synchronous, active-high reset; single clock domain.
- `in_valid` in 1 — input word valid.
- `in_ready` out 1 — padder accepts a word this cycle.
- `in_data` in 32 — message word; first byte in [31:24].
- `in_last` in 1 — this word ends the message.
- `in_bytes` in 3 — valid bytes in a last word (0..4); ignored when `in_last`=0, where the word counts as 4 bytes.
- `chunk_valid` out 1 — chunk output valid.
- `chunk_ready` in 1 — downstream accepts the chunk.
- `chunk_data` out 512 — padded chunk; word i at [32*i+:32].
- `chunk_first` out 1 — first chunk of the message; downstream uses the IV.
- `chunk_last` out 1 — final chunk of the message; downstream finalises the digest.
- `msg_count` out 32 — messages completed. Present only with `SHA256_PAD_STATS_EN`.

## Operation
- States: FILL, EMIT, TAIL.
- FILL: `in_ready`=1. Each accepted word is written to index `idx` (4 bits) and `bitlen` (64 bits) is incremented by 32, or by 8*`in_bytes` on the last word.
- Non-last word at `idx`=15 → EMIT with `chunk_last`=0.
- Last word: bytes beyond `in_bytes` are zeroed. The 0x80 marker goes at byte `in_bytes` of that word; when `in_bytes`=4 it goes as 0x80000000 in word `idx`+1. Let p be the index of the word that holds the marker.
  - p ≤ 13: zero words p+1..13, word14 = `bitlen[63:32]`, word15 = `bitlen[31:0]`. Go to EMIT with `chunk_last`=1.
  - p = 14 or 15: zero the rest of the chunk and go to EMIT with `chunk_last`=0, setting `tail_pend`.
  - p = 16 (last word full at `idx`=15): go to EMIT with `chunk_last`=0, setting `tail_pend` and `tail_mark`.
- EMIT: `chunk_valid`=1. On `chunk_valid && chunk_ready`:
  - `tail_pend` set → TAIL.
  - Otherwise → FILL, clearing the buffer, and `idx`=0.
- TAIL (one cycle, no output): build the closing chunk. Word0 = 0x80000000 if `tail_mark` else 0; words 1..13 = 0; words 14/15 = length. Set `chunk_last`=1 and go to EMIT.
- `chunk_first` is set for the first chunk after reset or after a completed message, and cleared after that chunk's handshake.
- Empty message: `in_last` with `in_bytes`=0 at `idx`=0 gives p=0, i.e. word0 = 0x80000000 and length 0.
- The byte-masking and marker insertion for one word is a combinational function of (`in_data`, `in_bytes`).

## Timing
- Reset values: `in_ready`=0 during reset and 1 from the first cycle after; `chunk_valid`=0; `chunk_data`=0; `chunk_first`=1; `chunk_last`=0; `idx`=0; `bitlen`=0; `msg_count`=0.
- `chunk_valid` rises the cycle after the word that completes a chunk is accepted.
- A TAIL chunk appears 2 cycles after the preceding handshake: 1 cycle in TAIL, then EMIT.
- Throughput: 16 input cycles + 1 emit cycle per chunk when `chunk_ready` is held high.
- While `chunk_valid && !chunk_ready`, `chunk_data`, `chunk_first` and `chunk_last` hold stable and `in_ready`=0.
- `reset` mid-message discards the partial chunk and `bitlen`. The next accepted word starts a new message with `chunk_first`=1.
- `bitlen` wraps modulo 2^64; no overflow flag.

## Configuration
- `SHA256_PAD_STATS_EN` defined: `msg_count` port exists and increments on the handshake of every chunk with `chunk_last`=1, wrapping at 2^32.
- Not defined: the port and the counter are absent; all other behaviour is identical.

## Structure
- Shared package `sha256_pkg`: H0..H7 IV constants, K00..K63 round constants, the state enum (FILL/EMIT/TAIL), and word/chunk width constants.
- One sub-module, `sha256_pad_word`: combinational byte mask plus 0x80 insertion for a single word.

## Test plan
- "abc": `in_data`=0x61626300, `in_bytes`=3, `in_last`=1 → one chunk: word0=0x61626380, words1–14=0, word15=0x00000018, `chunk_first`=1, `chunk_last`=1.
- Empty message (`in_bytes`=0, `in_last`=1) → word0=0x80000000, all other words 0, word15=0.
- 56-byte message (14 full words, last with `in_bytes`=4) → chunk A: word14=0x80000000, word15=0, `chunk_last`=0. Chunk B: words0–14=0, word15=0x000001C0, `chunk_first`=0, `chunk_last`=1.
- 64-byte message → chunk A = the data, `chunk_last`=0. Chunk B: word0=0x80000000, word15=0x00000200.
- `chunk_ready` held low for 5 cycles during EMIT → `chunk_data` unchanged, `in_ready`=0 throughout, and exactly one handshake occurs.
- `reset` after 7 words, then "abc" → output identical to the "abc" case. With `SHA256_PAD_STATS_EN` defined, `msg_count`=1.
